cpu7_exu_ilk: RTL



---
 rtl/cpu7_exu_ilk.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu7_exu_ilk.sv
// ---------------------------------------------------------------------------
// cpu7_exu_ilk
//
// Pipeline interlock and bypass controller for the cpu7 single-issue EXU.
// It tracks the destination, write-enable and producer class of the
// instructions in E, M and W. It compares each decode-stage source against
// those entries and produces two results: the operand bypass selects and the
// decode stall. It also sequences multi-cycle MDU ops, which hold the E stage.
//
// Build option:
//   CPU7_EXU_BYPASS_EN  defined   -> full forwarding from E/M/W
//                       undefined -> no forwarding; sels tied to 0 and any
//                                    RAW match stalls D until the producer
//                                    has retired from W
//
// Parameters:
//   MDU_LAT             cycles an MDU op occupies E (2..15)
//
// Ports:
//   clk, resetn             core clock, asynchronous active-low reset
//   ifu_exu_valid/flush     D-stage valid and D-stage kill
//   ilk_rs1_d/ilk_rs2_d     D source registers
//   ilk_rs1_rd_d/_rs2_rd_d  source actually read
//   ifu_exu_rf_wen/_target  D write-enable and destination
//   ilk_is_load_d/_mdu_d    D producer class
//   ilk_rs1_sel_d/_rs2_sel_d operand select: 0 RF, 1 E, 2 M, 3 W
//   exu_ifu_stall_d         hold D
//   ilk_valid_*/wen_*/rd_*  E/M/W stage tracking
//   ilk_mdu_start_e         pulse on the first E cycle of an MDU op
//   ilk_mdu_busy            MDU sequencer busy
// ---------------------------------------------------------------------------
module cpu7_exu_ilk #(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ifu_exu_valid,
  input  logic       ifu_exu_flush,
  input  logic [4:0] ilk_rs1_d,
  input  logic [4:0] ilk_rs2_d,
  input  logic       ilk_rs1_rd_d,
  input  logic       ilk_rs2_rd_d,
  input  logic       ifu_exu_rf_wen,
  input  logic [4:0] ifu_exu_rf_target,
  input  logic       ilk_is_load_d,
  input  logic       ilk_is_mdu_d,
  output logic [1:0] ilk_rs1_sel_d,
  output logic [1:0] ilk_rs2_sel_d,
  output logic       exu_ifu_stall_d,
  output logic       ilk_valid_e,
  output logic       ilk_valid_m,
  output logic       ilk_valid_w,
  output logic       ilk_wen_e,
  output logic       ilk_wen_m,
  output logic       ilk_wen_w,
  output logic [4:0] ilk_rd_e,
  output logic [4:0] ilk_rd_m,
  output logic [4:0] ilk_rd_w,
  output logic       ilk_mdu_start_e,
  output logic       ilk_mdu_busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BUSY  = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(MDU_LAT - 1);

  // Producer class is only needed where it changes forwarding: a load is
  // not ready in E or M, and an MDU op is not ready until its last E cycle.
  // A load in W and an MDU result in M/W forward like any ALU result.
  logic       load_e;
  logic       load_m;
  logic       mdu_e;

  logic [0:0] state;
  logic [3:0] cnt;

  logic       wen_d;
  logic       busy;
  logic       e_hold;
  logic       mdu_busy_hold;
  logic       hazard;
  logic       take_d;
  logic [2:0] hit1;
  logic [2:0] hit2;

  assign wen_d  = ifu_exu_valid & ifu_exu_rf_wen & (ifu_exu_rf_target != 5'd0);
  assign busy   = (state == ST_BUSY);
  // E stays occupied on every busy count except the final one (cnt == 0).
  assign e_hold = busy & (cnt != 4'd0);
  // D also waits out the whole busy window with a second MDU op, so two MDU
  // ops never overlap in the sequencer.
  assign mdu_busy_hold = e_hold | (busy & ilk_is_mdu_d);

  // Per-source match vectors, bit order {E, M, W}. Stage wen already
  // excludes r0, and the explicit rs != 0 keeps r0 out for reads as well.
  assign hit1[2] = ilk_rs1_rd_d & (ilk_rs1_d != 5'd0) & ilk_wen_e & (ilk_rd_e == ilk_rs1_d);
  assign hit1[1] = ilk_rs1_rd_d & (ilk_rs1_d != 5'd0) & ilk_wen_m & (ilk_rd_m == ilk_rs1_d);
  assign hit1[0] = ilk_rs1_rd_d & (ilk_rs1_d != 5'd0) & ilk_wen_w & (ilk_rd_w == ilk_rs1_d);
  assign hit2[2] = ilk_rs2_rd_d & (ilk_rs2_d != 5'd0) & ilk_wen_e & (ilk_rd_e == ilk_rs2_d);
  assign hit2[1] = ilk_rs2_rd_d & (ilk_rs2_d != 5'd0) & ilk_wen_m & (ilk_rd_m == ilk_rs2_d);
  assign hit2[0] = ilk_rs2_rd_d & (ilk_rs2_d != 5'd0) & ilk_wen_w & (ilk_rd_w == ilk_rs2_d);

`ifdef CPU7_EXU_BYPASS_EN

  // Youngest producer wins: E over M over W.
  function automatic logic [1:0] sel_code(input logic [2:0] hit);
    logic [1:0] code;
    code = 2'd0;
    if (hit[2])      code = 2'd1;
    else if (hit[1]) code = 2'd2;
    else if (hit[0]) code = 2'd3;
    return code;
  endfunction

  // Only the winning producer decides whether the value is ready yet.
  function automatic logic not_ready(input logic [2:0] hit, input logic ld_e,
                                     input logic ld_m, input logic md_hold);
    return (hit[2] & (ld_e | md_hold)) | (~hit[2] & hit[1] & ld_m);
  endfunction

  assign hazard = not_ready(hit1, load_e, load_m, mdu_e & e_hold)
                | not_ready(hit2, load_e, load_m, mdu_e & e_hold);

  assign ilk_rs1_sel_d = ifu_exu_valid ? sel_code(hit1) : 2'd0;
  assign ilk_rs2_sel_d = ifu_exu_valid ? sel_code(hit2) : 2'd0;

`else

  // Without forwarding every in-flight producer must drain through W first,
  // so the producer class no longer matters.
  logic unused_class;
  assign unused_class = load_m ^ mdu_e;

  assign hazard = (|hit1) | (|hit2);

  assign ilk_rs1_sel_d = 2'd0;
  assign ilk_rs2_sel_d = 2'd0;

`endif

  assign exu_ifu_stall_d = ifu_exu_valid & (hazard | mdu_busy_hold);

  // A flush kills D even when the stall is also active.
  assign take_d = ifu_exu_valid & ~ifu_exu_flush & ~exu_ifu_stall_d;

  assign ilk_mdu_busy    = busy;
  assign ilk_mdu_start_e = busy & (cnt == CNT_INIT);

  // Stage advance. W always takes M. While the MDU holds E, E keeps its
  // entry and a bubble enters M. Otherwise the pipe shifts and E takes D or
  // a bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ilk_valid_e <= 1'b0;
      ilk_wen_e   <= 1'b0;
      ilk_rd_e    <= 5'd0;
      load_e      <= 1'b0;
      mdu_e       <= 1'b0;
      ilk_valid_m <= 1'b0;
      ilk_wen_m   <= 1'b0;
      ilk_rd_m    <= 5'd0;
      load_m      <= 1'b0;
      ilk_valid_w <= 1'b0;
      ilk_wen_w   <= 1'b0;
      ilk_rd_w    <= 5'd0;
    end else begin
      ilk_valid_w <= ilk_valid_m;
      ilk_wen_w   <= ilk_wen_m;
      ilk_rd_w    <= ilk_rd_m;
      if (e_hold) begin
        ilk_valid_m <= 1'b0;
        ilk_wen_m   <= 1'b0;
        ilk_rd_m    <= 5'd0;
        load_m      <= 1'b0;
      end else begin
        ilk_valid_m <= ilk_valid_e;
        ilk_wen_m   <= ilk_wen_e;
        ilk_rd_m    <= ilk_rd_e;
        load_m      <= load_e;
        if (take_d) begin
          ilk_valid_e <= 1'b1;
          ilk_wen_e   <= wen_d;
          ilk_rd_e    <= ifu_exu_rf_target;
          load_e      <= ilk_is_load_d;
          mdu_e       <= ilk_is_mdu_d;
        end else begin
          ilk_valid_e <= 1'b0;
          ilk_wen_e   <= 1'b0;
          ilk_rd_e    <= 5'd0;
          load_e      <= 1'b0;
          mdu_e       <= 1'b0;
        end
      end
    end
  end

  // MDU occupancy sequencer. The count runs MDU_LAT-1 down to 0; the op
  // leaves E on the edge that ends the cnt == 0 cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else if (state == ST_IDLE) begin
      if (take_d && ilk_is_mdu_d) begin
        state <= ST_BUSY;
        cnt   <= CNT_INIT;
      end
    end else begin
      if (cnt == 4'd0) begin
        state <= ST_IDLE;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule
